ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Hazard scheduler for the 5-stage pipeline; sits beside the ID stage and drives the EX-stage operand muxes.
//  - Tracks destination register, wreg and m2reg of the instructions in EX, MEM and WB with its own shadow registers.
//  - Produces the forwarding selects id_fwda/id_fwdb, which the ID/EX register carries into EX.
//  - Inserts a one-cycle load-use stall, and squashes IF/ID and ID/EX when a branch resolves taken in EX.
//  - Keeps saturating stall/flush performance counters.
// PARAMETERS
//  RW     5   register-index width
//  CNT_W  16  width of each performance counter
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous reset, active-high
//  id_valid        in   1      ID holds a real instruction; 0 = bubble
//  id_rs           in   RW     ID source A index
//  id_rt           in   RW     ID source B index
//  id_use_rs       in   1      ID reads rs through the ALU A port
//  id_use_rt       in   1      ID reads rt through the ALU B port (not imm)
//  id_wreg         in   1      ID writes a register
//  id_m2reg        in   1      ID is a load
//  id_destR        in   RW     ID destination index
//  ex_taken        in   1      ex_branch & ex_zero, taken branch in EX this cycle
//  id_fwda         out  2      00 = regfile, 01 = mem_aluR, 10 = wb_dest
//  id_fwdb         out  2      same encoding as id_fwda
//  pc_stall        out  1      hold PC
//  ifid_stall      out  1      hold IF/ID
//  idex_bubble     out  1      load NOP controls into ID/EX
//  ifid_flush      out  1      clear IF/ID to NOP
//  ctrl_state      out  2      00 RUN, 01 LU_STALL, 10 FLUSH (registered)
//  stall_cnt       out  CNT_W  cycles with a load-use stall
//  flush_cnt       out  CNT_W  taken-branch flush events
// BEHAVIOUR
//  Shadows
//  - Three entries, ex / mem / wb, each {v, wreg, m2reg, dest}; v = valid.
//  - Every edge: wb <= mem; mem <= ex.
//  - ex <= ID fields when id_valid & !idex_bubble; otherwise ex.v <= 0.
//  Match rules
//  - match(S, r) = S.v & S.wreg & (S.dest == r) & (r != 0).
//  - A shadow entry is never matched against register 0.
//  - The regfile writes before it reads, so the wb entry is never a forward source.
//  Forwarding (combinational, for operand rs; rt is identical with id_use_rt)
//  - match(ex, rs) & !ex.m2reg gives id_fwda = 01; the producer is in MEM when ID reaches EX.
//  - Otherwise match(mem, rs) gives id_fwda = 10; this covers load data.
//  - Otherwise id_fwda = 00.
//  - The ex entry has priority over the mem entry (youngest producer wins).
//  - id_fwda is forced to 00 when id_use_rs = 0 or id_valid = 0.
//  Load-use
//  - lu = id_valid & ex.m2reg & ((id_use_rs & match(ex, id_rs)) | (id_use_rt & match(ex, id_rt))).
//  - lu drives pc_stall = ifid_stall = idex_bubble = 1.
//  - It lasts exactly one cycle: the next cycle the load is in mem and the select resolves to 10.
//  Branch
//  - ex_taken drives ifid_flush = idex_bubble = 1 in the same cycle.
//  - On ex_taken, pc_stall = ifid_stall = 0, overriding lu. The PC takes the branch target.
//  FSM (ctrl_state, next-state)
//  - ex_taken gives FLUSH; else lu gives LU_STALL; else RUN.
//  - Any state can reach any state. ctrl_state only reports the previous cycle's action.
//  Counters
//  - stall_cnt += 1 on each cycle with lu & !ex_taken.
//  - flush_cnt += 1 on each cycle with ex_taken.
//  - Both saturate at all-ones; no wrap.
//  Reset
//  - All shadow v bits = 0, ctrl_state = RUN, both counters = 0.
//  - The combinational outputs are 0 while the shadows are empty.
//  - A reset in mid-stall or mid-flush drops the pending hazard; there is no stall on the cycle after rst.
//  Latency: all hazard outputs are combinational from the current inputs and shadows; nothing waits a cycle.
// TESTING
//  T1 add r3 in EX, then ID = sub r4,r3,r5 (rs = 3) -> id_fwda = 01, id_fwdb = 00, no stall.
//  T2 add r3, nop, then ID reads r3 on rt -> id_fwdb = 10. Writing r0 in EX with ID reading r0 -> 00.
//  T3 lw r2 in EX, ID reads r2 -> one cycle with pc_stall = ifid_stall = idex_bubble = 1, stall_cnt = 1.
//     The next cycle has id_fwda = 10 and no stall.
//  T4 lw r2 in EX, ID reads r2, ex_taken = 1 in the same cycle -> ifid_flush = idex_bubble = 1,
//     pc_stall = 0, ctrl_state -> FLUSH, flush_cnt = 1, stall_cnt unchanged.
//  T5 add r3 in EX, add r3 in MEM, ID reads r3 -> id_fwda = 01 (EX priority).
//  T6 CNT_W = 2, 5 consecutive load-use stalls -> stall_cnt = 3 and holds.
//     rst pulsed mid-stall -> counters 0, state RUN, no stall next cycle.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if
//   Bundle between the ID stage and the hazard scheduler.
//   master : ID-side driver (decoded ID fields, ex_taken) that consumes the
//            forwarding selects, stall/flush strobes, state and counters.
//   slave  : the hazard scheduler itself.
//   RW     : register-index width, CNT_W : performance counter width.
interface ex_hazard_ctrl_if #(
    parameter int RW    = 5,
    parameter int CNT_W = 16
);
    // ID-side inputs to the scheduler
    logic             id_valid;
    logic [RW-1:0]    id_rs;
    logic [RW-1:0]    id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [RW-1:0]    id_destR;
    logic             ex_taken;
    // scheduler outputs
    logic [1:0]       id_fwda;
    logic [1:0]       id_fwdb;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_destR, ex_taken,
        input  id_fwda, id_fwdb, pc_stall, ifid_stall, idex_bubble,
               ifid_flush, ctrl_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_destR, ex_taken,
        output id_fwda, id_fwdb, pc_stall, ifid_stall, idex_bubble,
               ifid_flush, ctrl_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   Hazard scheduler for the 5-stage pipeline. Shadows the EX/MEM/WB
//   producers, generates EX operand forwarding selects for the instruction
//   in ID, a one-cycle load-use stall, and the taken-branch squash.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous reset, active-high
//     hz   : ex_hazard_ctrl_if.slave (ID fields in; fwd selects, stall/flush
//            strobes, ctrl_state, saturating stall/flush counters out)
//   All hazard outputs are combinational; ctrl_state and counters are
//   registered.
module ex_hazard_ctrl #(
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    ex_hazard_ctrl_if.slave  hz
);

    typedef struct packed {
        logic          v;
        logic          wreg;
        logic          m2reg;
        logic [RW-1:0] dest;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    shadow_t ex_q, mem_q, wb_q;
    state_t  state_q, state_nxt;
    logic    lu;

    // r0 is hard-wired zero, so a producer targeting it never matches.
    function automatic logic match(input shadow_t s, input logic [RW-1:0] r);
        return s.v & s.wreg & (s.dest == r) & (r != '0);
    endfunction

    // Operand 0 = rs (ALU A), operand 1 = rt (ALU B); identical rules.
    logic [1:0][RW-1:0] op_idx;
    logic [1:0]         op_use;
    logic [1:0]         op_ld_hit;
    logic [1:0][1:0]    op_fwd;

    assign op_idx[0] = hz.id_rs;
    assign op_idx[1] = hz.id_rt;
    assign op_use[0] = hz.id_valid & hz.id_use_rs;
    assign op_use[1] = hz.id_valid & hz.id_use_rt;

    for (genvar i = 0; i < 2; i++) begin : g_op
        // Youngest producer wins; a load in EX cannot forward yet (stall
        // covers it), and WB never forwards since the regfile is write-first.
        always_comb begin
            op_fwd[i] = FWD_RF;
            if (op_use[i]) begin
                if (match(ex_q, op_idx[i]) && !ex_q.m2reg)
                    op_fwd[i] = FWD_MEM;
                else if (match(mem_q, op_idx[i]))
                    op_fwd[i] = FWD_WB;
            end
        end
        assign op_ld_hit[i] = op_use[i] & match(ex_q, op_idx[i]);
    end

    assign lu = hz.id_valid & ex_q.m2reg & (|op_ld_hit);

    assign hz.id_fwda = op_fwd[0];
    assign hz.id_fwdb = op_fwd[1];

    // A taken branch wins over load-use: the PC must move to the target,
    // and the stalled consumer is on the wrong path anyway.
    assign hz.pc_stall    = lu & ~hz.ex_taken;
    assign hz.ifid_stall  = lu & ~hz.ex_taken;
    assign hz.idex_bubble = lu | hz.ex_taken;
    assign hz.ifid_flush  = hz.ex_taken;
    assign hz.ctrl_state  = state_q;

    // Shadow pipeline mirrors what the ID/EX, EX/MEM, MEM/WB registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q       <= mem_q;
            mem_q      <= ex_q;
            ex_q.v     <= hz.id_valid & ~hz.idex_bubble;
            ex_q.wreg  <= hz.id_wreg;
            ex_q.m2reg <= hz.id_m2reg & hz.id_valid & ~hz.idex_bubble;
            ex_q.dest  <= hz.id_destR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_RUN;
        if (hz.ex_taken) state_nxt = ST_FLUSH;
        else if (lu)     state_nxt = ST_LU_STALL;
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hz.stall_cnt <= '0;
            hz.flush_cnt <= '0;
        end else begin
            if (lu && !hz.ex_taken && hz.stall_cnt != '1)
                hz.stall_cnt <= hz.stall_cnt + 1'b1;
            if (hz.ex_taken && hz.flush_cnt != '1)
                hz.flush_cnt <= hz.flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl
//   Directed bench for ex_hazard_ctrl. Instance A (CNT_W=16) covers
//   forwarding, load-use and branch squash; instance B (CNT_W=2) covers
//   counter saturation and reset in mid-stall. Inputs change on the falling
//   edge and outputs are sampled 2 time units later, before the next rise.
module tb_ex_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.RW(5), .CNT_W(16)) ha ();
    ex_hazard_ctrl_if #(.RW(5), .CNT_W(2))  hb ();

    ex_hazard_ctrl #(.RW(5), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hz(ha));
    ex_hazard_ctrl #(.RW(5), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .hz(hb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // args: valid, rs, rt, use_rs, use_rt, wreg, m2reg, dest, ex_taken
    task automatic drive_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic w,
                           input logic m, input logic [4:0] d, input logic tk);
        @(negedge clk);
        ha.id_valid = v;  ha.id_rs = rs; ha.id_rt = rt;
        ha.id_use_rs = urs; ha.id_use_rt = urt;
        ha.id_wreg = w; ha.id_m2reg = m; ha.id_destR = d; ha.ex_taken = tk;
        #2;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic w,
                           input logic m, input logic [4:0] d, input logic tk);
        @(negedge clk);
        hb.id_valid = v;  hb.id_rs = rs; hb.id_rt = rt;
        hb.id_use_rs = urs; hb.id_use_rt = urt;
        hb.id_wreg = w; hb.id_m2reg = m; hb.id_destR = d; hb.ex_taken = tk;
        #2;
    endtask

    task automatic idle_a(input int n);
        repeat (n) drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ha.id_valid = 0; ha.id_rs = 0; ha.id_rt = 0; ha.id_use_rs = 0; ha.id_use_rt = 0;
        ha.id_wreg = 0; ha.id_m2reg = 0; ha.id_destR = 0; ha.ex_taken = 0;
        hb.id_valid = 0; hb.id_rs = 0; hb.id_rt = 0; hb.id_use_rs = 0; hb.id_use_rt = 0;
        hb.id_wreg = 0; hb.id_m2reg = 0; hb.id_destR = 0; hb.ex_taken = 0;

        // reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_fwda",  32'(ha.id_fwda), 0);
        chk("rst_fwdb",  32'(ha.id_fwdb), 0);
        chk("rst_stall", 32'(ha.pc_stall), 0);
        chk("rst_bub",   32'(ha.idex_bubble), 0);
        chk("rst_state", 32'(ha.ctrl_state), 0);
        chk("rst_scnt",  32'(ha.stall_cnt), 0);
        chk("rst_fcnt",  32'(ha.flush_cnt), 0);
        rst = 0;

        // T1: add r3 in EX, ID sub r4,r3,r5 -> fwda=01
        drive_a(1, 1, 2, 1, 1, 1, 0, 3, 0);
        drive_a(1, 3, 5, 1, 1, 1, 0, 4, 0);
        chk("t1_fwda",  32'(ha.id_fwda), 1);
        chk("t1_fwdb",  32'(ha.id_fwdb), 0);
        chk("t1_stall", 32'(ha.pc_stall), 0);
        idle_a(3);

        // T2: add r3, nop, ID reads r3 on rt -> fwdb=10
        drive_a(1, 1, 2, 1, 1, 1, 0, 3, 0);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_a(1, 7, 3, 1, 1, 0, 0, 0, 0);
        chk("t2_fwdb", 32'(ha.id_fwdb), 2);
        chk("t2_fwda", 32'(ha.id_fwda), 0);
        idle_a(3);
        // writer of r0 in EX, ID reads r0 on both ports
        drive_a(1, 1, 2, 1, 1, 1, 0, 0, 0);
        drive_a(1, 0, 0, 1, 1, 1, 0, 9, 0);
        chk("t2_r0a", 32'(ha.id_fwda), 0);
        chk("t2_r0b", 32'(ha.id_fwdb), 0);
        idle_a(3);

        // T3: lw r2 in EX, ID reads r2 -> one stall cycle
        drive_a(1, 1, 0, 1, 0, 1, 1, 2, 0);
        drive_a(1, 2, 6, 1, 1, 1, 0, 7, 0);
        chk("t3_pcst",  32'(ha.pc_stall), 1);
        chk("t3_ifst",  32'(ha.ifid_stall), 1);
        chk("t3_bub",   32'(ha.idex_bubble), 1);
        chk("t3_flsh",  32'(ha.ifid_flush), 0);
        chk("t3_fwda0", 32'(ha.id_fwda), 0);
        drive_a(1, 2, 6, 1, 1, 1, 0, 7, 0);
        chk("t3_scnt",  32'(ha.stall_cnt), 1);
        chk("t3_state", 32'(ha.ctrl_state), 1);
        chk("t3_pcst2", 32'(ha.pc_stall), 0);
        chk("t3_fwda1", 32'(ha.id_fwda), 2);
        chk("t3_fwdb1", 32'(ha.id_fwdb), 0);
        idle_a(3);
        chk("t3_run", 32'(ha.ctrl_state), 0);

        // T4: load-use and taken branch together -> flush wins
        drive_a(1, 1, 0, 1, 0, 1, 1, 2, 0);
        drive_a(1, 2, 6, 1, 1, 1, 0, 7, 1);
        chk("t4_flsh", 32'(ha.ifid_flush), 1);
        chk("t4_bub",  32'(ha.idex_bubble), 1);
        chk("t4_pcst", 32'(ha.pc_stall), 0);
        chk("t4_ifst", 32'(ha.ifid_stall), 0);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_state", 32'(ha.ctrl_state), 2);
        chk("t4_fcnt",  32'(ha.flush_cnt), 1);
        chk("t4_scnt",  32'(ha.stall_cnt), 1);
        chk("t4_nobub", 32'(ha.idex_bubble), 0);
        idle_a(3);

        // T5: add r3 in EX and in MEM -> EX priority
        drive_a(1, 1, 2, 1, 1, 1, 0, 3, 0);
        drive_a(1, 1, 2, 1, 1, 1, 0, 3, 0);
        drive_a(1, 3, 3, 1, 0, 1, 0, 8, 0);
        chk("t5_fwda", 32'(ha.id_fwda), 1);
        chk("t5_fwdb_unused", 32'(ha.id_fwdb), 0);
        ha.id_valid = 0;
        #1;
        chk("t5_novalid", 32'(ha.id_fwda), 0);
        idle_a(2);

        // T6: CNT_W=2 saturation on instance B
        for (int i = 0; i < 5; i++) begin
            drive_b(1, 1, 0, 1, 0, 1, 1, 2, 0);
            drive_b(1, 2, 6, 1, 1, 1, 0, 7, 0);
            chk("t6_lu", 32'(hb.pc_stall), 1);
            drive_b(1, 2, 6, 1, 1, 1, 0, 7, 0);
            chk("t6_scnt", 32'(hb.stall_cnt), (i < 3) ? i + 1 : 3);
        end
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_fcnt", 32'(hb.flush_cnt), 1);
        // reset asserted during a load-use stall
        drive_b(1, 1, 0, 1, 0, 1, 1, 2, 0);
        drive_b(1, 2, 6, 1, 1, 1, 0, 7, 0);
        chk("t6_lu_pre", 32'(hb.pc_stall), 1);
        rst = 1;
        drive_b(1, 2, 6, 1, 1, 1, 0, 7, 0);
        rst = 0;
        chk("t6_rst_scnt",  32'(hb.stall_cnt), 0);
        chk("t6_rst_fcnt",  32'(hb.flush_cnt), 0);
        chk("t6_rst_state", 32'(hb.ctrl_state), 0);
        chk("t6_rst_stall", 32'(hb.pc_stall), 0);
        chk("t6_rst_fwda",  32'(hb.id_fwda), 0);
        drive_b(1, 2, 6, 1, 1, 1, 0, 7, 0);
        chk("t6_post_stall", 32'(hb.pc_stall), 0);
        chk("t6_post_state", 32'(hb.ctrl_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
